// File: rtl/sh7604_frt_intc_if.sv
// IBUS register port and CPU interrupt-request port of the SH7604 FRT interrupt stage.
// The slave modport is the FRT interrupt block; master is the CPU/bus side.
interface sh7604_frt_intc_if;
  logic [31:0] ibus_a;
  logic [31:0] ibus_di;
  logic [31:0] ibus_do;
  logic [3:0]  ibus_ba;
  logic        ibus_we;
  logic        ibus_req;
  logic        ibus_busy;
  logic        ibus_act;
  logic        int_req;
  logic [3:0]  int_lvl;
  logic [6:0]  int_vec;
  logic [1:0]  int_src;
  logic        int_ack;

  modport slave (
    input  ibus_a, ibus_di, ibus_ba, ibus_we, ibus_req, int_ack,
    output ibus_do, ibus_busy, ibus_act, int_req, int_lvl, int_vec, int_src
  );

  modport master (
    output ibus_a, ibus_di, ibus_ba, ibus_we, ibus_req, int_ack,
    input  ibus_do, ibus_busy, ibus_act, int_req, int_lvl, int_vec, int_src
  );
endinterface

// File: rtl/sh7604_frt_intc.sv
// SH7604 FRT interrupt stage: arbitrates ICI/OCI/OVI, applies IPR/VCRC/VCRD, requests the CPU.
// Optional macro FRT_INTC_ACK_CNT_EN adds per-source acknowledge counters at FFFFFE6C.
module sh7604_frt_intc #(
  parameter int unsigned ACK_BLANK = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_ce_r,
  input  logic              i_ce_f,
  input  logic              i_en,
  input  logic              i_res_n,
  input  logic              i_ici_irq,
  input  logic              i_ocia_irq,
  input  logic              i_ocib_irq,
  input  logic              i_ovi_irq,
  sh7604_frt_intc_if.slave  bus_if
);

  localparam logic [31:0] AddrE60 = 32'hFFFF_FE60;
  localparam logic [29:0] LwE64   = 30'h3FFF_FF99;
  localparam logic [29:0] LwE68   = 30'h3FFF_FF9A;
`ifdef FRT_INTC_ACK_CNT_EN
  localparam logic [29:0] LwE6C   = 30'h3FFF_FF9B;
`endif

  typedef enum logic [1:0] {StIdle, StReq, StBlank} state_e;

  state_e      r_state;
  state_e      w_state_next;
  logic [3:0]  r_blank_cnt;
  logic [3:0]  r_ipr;
  logic [6:0]  r_ficv;
  logic [6:0]  r_focv;
  logic [6:0]  r_fovv;
  logic [3:0]  r_lvl;
  logic [6:0]  r_vec;
  logic [1:0]  r_src;
  logic [31:0] r_do;

  logic        w_sel_e60;
  logic        w_sel_e64;
  logic        w_sel_e68;
  logic        w_act;
  logic        w_wr;
  logic [31:0] w_rd_data;
  logic        w_oci;
  logic        w_any;
  logic        w_go;
  logic [1:0]  w_src;
  logic [6:0]  w_vec;
  logic        w_blank_done;
  logic        w_load;
  logic        w_unused;

  // Bus decode: read image is per longword, ACT only for the implemented byte addresses.
  assign w_sel_e60 = (bus_if.ibus_a[31:2] == AddrE60[31:2]);
  assign w_sel_e64 = (bus_if.ibus_a[31:2] == LwE64);
  assign w_sel_e68 = (bus_if.ibus_a[31:2] == LwE68);

`ifdef FRT_INTC_ACK_CNT_EN
  logic       w_sel_e6c;
  logic       w_ack_acc;
  logic [7:0] r_cnt_ici;
  logic [7:0] r_cnt_oci;
  logic [7:0] r_cnt_ovi;

  assign w_sel_e6c = (bus_if.ibus_a[31:2] == LwE6C);
  assign w_act     = (bus_if.ibus_a == AddrE60) || (w_sel_e64 && bus_if.ibus_a[1]) ||
                     (w_sel_e68 && !bus_if.ibus_a[1]) || w_sel_e6c;
`else
  assign w_act     = (bus_if.ibus_a == AddrE60) || (w_sel_e64 && bus_if.ibus_a[1]) ||
                     (w_sel_e68 && !bus_if.ibus_a[1]);
`endif

  assign w_wr = i_ce_r && i_en && bus_if.ibus_req && bus_if.ibus_we && w_act;

  assign w_unused = ^{bus_if.ibus_di[31], bus_if.ibus_di[23:15], bus_if.ibus_di[7],
                      bus_if.ibus_ba[2]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ipr  <= '0;
      r_ficv <= '0;
      r_focv <= '0;
      r_fovv <= '0;
    end else if (i_ce_r) begin
      if (!i_res_n) begin
        r_ipr  <= '0;
        r_ficv <= '0;
        r_focv <= '0;
        r_fovv <= '0;
      end else if (w_wr) begin
        if (w_sel_e60 && bus_if.ibus_ba[3]) r_ipr  <= bus_if.ibus_di[27:24];
        if (w_sel_e64 && bus_if.ibus_ba[1]) r_ficv <= bus_if.ibus_di[14:8];
        if (w_sel_e64 && bus_if.ibus_ba[0]) r_focv <= bus_if.ibus_di[6:0];
        if (w_sel_e68 && bus_if.ibus_ba[3]) r_fovv <= bus_if.ibus_di[30:24];
      end
    end
  end

  always_comb begin
    w_rd_data = '0;
    if (bus_if.ibus_req && !bus_if.ibus_we) begin
      if (w_sel_e60) w_rd_data[31:24] = {4'h0, r_ipr};
      if (w_sel_e64) w_rd_data[15:0]  = {1'b0, r_ficv, 1'b0, r_focv};
      if (w_sel_e68) w_rd_data[31:16] = {1'b0, r_fovv, 8'h00};
`ifdef FRT_INTC_ACK_CNT_EN
      if (w_sel_e6c) w_rd_data[31:8]  = {r_cnt_ici, r_cnt_oci, r_cnt_ovi};
`endif
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_do <= '0;
    end else if (i_ce_f) begin
      r_do <= w_rd_data;
    end
  end

  // Fixed priority ICI > OCI > OVI, using the registers as they stood before this CE_R.
  assign w_oci = i_ocia_irq || i_ocib_irq;
  assign w_any = i_ici_irq || w_oci || i_ovi_irq;
  assign w_go  = w_any && (r_ipr != 4'h0);

  always_comb begin
    w_src = 2'd2;
    w_vec = r_fovv;
    if (i_ici_irq) begin
      w_src = 2'd0;
      w_vec = r_ficv;
    end else if (w_oci) begin
      w_src = 2'd1;
      w_vec = r_focv;
    end
  end

  assign w_blank_done = (r_blank_cnt == 4'(ACK_BLANK - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else if (i_ce_r) begin
      if (!i_res_n) begin
        r_state <= StIdle;
      end else if (i_en) begin
        r_state <= w_state_next;
      end
    end
  end

  // The last blank cycle evaluates like IDLE so INT_REQ is low for exactly ACK_BLANK cycles.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_go) w_state_next = StReq;
      StReq: begin
        if (bus_if.int_ack) begin
          w_state_next = StBlank;
        end else if (!w_go) begin
          w_state_next = StIdle;
        end
      end
      StBlank: if (w_blank_done) w_state_next = w_go ? StReq : StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Ack moves to BLANK, so the request fields stay frozen from the ack cycle onward.
  assign w_load = (w_state_next == StReq);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_blank_cnt <= '0;
      r_lvl       <= '0;
      r_vec       <= '0;
      r_src       <= '0;
    end else if (i_ce_r) begin
      if (!i_res_n) begin
        r_blank_cnt <= '0;
        r_lvl       <= '0;
        r_vec       <= '0;
        r_src       <= '0;
      end else if (i_en) begin
        r_blank_cnt <= (r_state == StBlank) ? r_blank_cnt + 4'd1 : 4'd0;
        if (w_load) begin
          r_lvl <= r_ipr;
          r_vec <= w_vec;
          r_src <= w_src;
        end
      end
    end
  end

`ifdef FRT_INTC_ACK_CNT_EN
  assign w_ack_acc = i_en && (r_state == StReq) && bus_if.int_ack;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt_ici <= '0;
      r_cnt_oci <= '0;
      r_cnt_ovi <= '0;
    end else if (i_ce_r) begin
      if (!i_res_n || (w_wr && w_sel_e6c)) begin
        r_cnt_ici <= '0;
        r_cnt_oci <= '0;
        r_cnt_ovi <= '0;
      end else if (w_ack_acc) begin
        case (r_src)
          2'd0:    if (r_cnt_ici != 8'hFF) r_cnt_ici <= r_cnt_ici + 8'd1;
          2'd1:    if (r_cnt_oci != 8'hFF) r_cnt_oci <= r_cnt_oci + 8'd1;
          2'd2:    if (r_cnt_ovi != 8'hFF) r_cnt_ovi <= r_cnt_ovi + 8'd1;
          default: ;
        endcase
      end
    end
  end
`endif

  always_comb begin
    bus_if.int_req   = (r_state == StReq);
    bus_if.int_lvl   = r_lvl;
    bus_if.int_vec   = r_vec;
    bus_if.int_src   = r_src;
    bus_if.ibus_do   = r_do;
    bus_if.ibus_busy = 1'b0;
    bus_if.ibus_act  = w_act;
  end

endmodule

// File: tb/tb_sh7604_frt_intc.sv
// Scoreboard bench for sh7604_frt_intc: expectations are queued as stimulus is driven
// and popped against the DUT outputs one CE_R (or CE_F for reads) later.
module tb_sh7604_frt_intc;
  localparam int unsigned AckBlank = 2;

  logic clk = 1'b0;
  logic rst, ce_r, ce_f, en, res_n;
  logic ici, ocia, ocib, ovi;

  sh7604_frt_intc_if bus_if ();

  sh7604_frt_intc #(
    .ACK_BLANK(AckBlank)
  ) u_dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_ce_r     (ce_r),
    .i_ce_f     (ce_f),
    .i_en       (en),
    .i_res_n    (res_n),
    .i_ici_irq  (ici),
    .i_ocia_irq (ocia),
    .i_ocib_irq (ocib),
    .i_ovi_irq  (ovi),
    .bus_if     (bus_if)
  );

  always #5 clk = ~clk;

  // CE_R and CE_F alternate clock by clock.
  initial begin
    ce_r = 1'b0;
    ce_f = 1'b0;
    forever begin
      @(negedge clk);
      ce_r = ~ce_r;
      ce_f = ~ce_r;
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, obs, e.val);
    end
  endtask

  function automatic logic [31:0] iv(input logic req, input logic [3:0] lvl,
                                     input logic [6:0] vec, input logic [1:0] src);
    return {18'h0, req, lvl, vec, src};
  endfunction

  function automatic logic [31:0] int_obs();
    return {18'h0, bus_if.int_req, bus_if.int_lvl, bus_if.int_vec, bus_if.int_src};
  endfunction

  task automatic tick();
    do @(posedge clk); while (ce_r !== 1'b1);
    #1;
  endtask

  task automatic step_chk(input string tag, input logic [31:0] exp);
    push_exp(tag, exp);
    tick();
    pop_cmp(int_obs());
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [3:0] ba, input logic [31:0] d);
    bus_if.ibus_a   = a;
    bus_if.ibus_ba  = ba;
    bus_if.ibus_di  = d;
    bus_if.ibus_we  = 1'b1;
    bus_if.ibus_req = 1'b1;
    tick();
    bus_if.ibus_req = 1'b0;
    bus_if.ibus_we  = 1'b0;
  endtask

  // Write and check the interrupt outputs produced by the same CE_R edge.
  task automatic wr_chk(input string tag, input logic [31:0] a, input logic [3:0] ba,
                        input logic [31:0] d, input logic [31:0] exp);
    push_exp(tag, exp);
    bus_wr(a, ba, d);
    pop_cmp(int_obs());
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    push_exp(tag, exp);
    bus_if.ibus_a   = a;
    bus_if.ibus_we  = 1'b0;
    bus_if.ibus_req = 1'b1;
    do @(posedge clk); while (ce_f !== 1'b1);
    #1;
    bus_if.ibus_req = 1'b0;
    pop_cmp(bus_if.ibus_do);
  endtask

  task automatic act_chk(input string tag, input logic [31:0] a, input logic exp);
    push_exp(tag, {31'h0, exp});
    bus_if.ibus_a = a;
    #1;
    pop_cmp({31'h0, bus_if.ibus_act});
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int w;
    rst = 1'b1;
    en = 1'b1;
    res_n = 1'b1;
    {ici, ocia, ocib, ovi} = 4'h0;
    bus_if.ibus_a   = '0;
    bus_if.ibus_di  = '0;
    bus_if.ibus_ba  = '0;
    bus_if.ibus_we  = 1'b0;
    bus_if.ibus_req = 1'b0;
    bus_if.int_ack  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    push_exp("rst_int", 32'h0);
    pop_cmp(int_obs());
    push_exp("rst_do", 32'h0);
    pop_cmp(bus_if.ibus_do);
    push_exp("busy", 32'h0);
    pop_cmp({31'h0, bus_if.ibus_busy});
    rst = 1'b0;
    tick();

    // Register programming and readback.
    bus_wr(32'hFFFF_FE60, 4'b1000, 32'h0500_0000);
    bus_wr(32'hFFFF_FE66, 4'b0011, 32'h0000_484A);
    bus_wr(32'hFFFF_FE68, 4'b1100, 32'h5000_0000);
    rd_chk("rd_e60", 32'hFFFF_FE60, 32'h0500_0000);
    rd_chk("rd_e64", 32'hFFFF_FE64, 32'h0000_484A);
    rd_chk("rd_e68", 32'hFFFF_FE68, 32'h5000_0000);
    act_chk("act_e60", 32'hFFFF_FE60, 1'b1);
    act_chk("act_e64", 32'hFFFF_FE64, 1'b0);
    act_chk("act_e69", 32'hFFFF_FE69, 1'b1);
`ifdef FRT_INTC_ACK_CNT_EN
    act_chk("act_e6c", 32'hFFFF_FE6C, 1'b1);
`else
    act_chk("act_e6c", 32'hFFFF_FE6C, 1'b0);
`endif

    // Basic request, withdraw, preemption.
    ocia = 1'b1;
    step_chk("oci_req", iv(1, 4'h5, 7'h4A, 2'd1));
    ocia = 1'b0;
    step_chk("oci_drop", iv(0, 4'h5, 7'h4A, 2'd1));
    ovi = 1'b1;
    step_chk("ovi_req", iv(1, 4'h5, 7'h50, 2'd2));
    ici = 1'b1;
    step_chk("ici_preempt", iv(1, 4'h5, 7'h48, 2'd0));

    // Acknowledge blanking with the flag still set.
    bus_if.int_ack = 1'b1;
    step_chk("ack_blank0", iv(0, 4'h5, 7'h48, 2'd0));
    bus_if.int_ack = 1'b0;
    step_chk("ack_blank1", iv(0, 4'h5, 7'h48, 2'd0));
    step_chk("ack_rereq", iv(1, 4'h5, 7'h48, 2'd0));

    // Ack coinciding with a source change keeps the acked vector.
    bus_if.int_ack = 1'b1;
    ici = 1'b0;
    step_chk("ack_coincide", iv(0, 4'h5, 7'h48, 2'd0));
    bus_if.int_ack = 1'b0;
    step_chk("coincide_blank", iv(0, 4'h5, 7'h48, 2'd0));
    step_chk("coincide_rereq", iv(1, 4'h5, 7'h50, 2'd2));
    ovi = 1'b0;
    step_chk("withdraw", iv(0, 4'h5, 7'h50, 2'd2));

    // Ack in IDLE must not start a blank period.
    bus_if.int_ack = 1'b1;
    step_chk("ack_idle", iv(0, 4'h5, 7'h50, 2'd2));
    bus_if.int_ack = 1'b0;
    ici = 1'b1;
    step_chk("req_after_idle_ack", iv(1, 4'h5, 7'h48, 2'd0));
    ici = 1'b0;
    step_chk("drop2", iv(0, 4'h5, 7'h48, 2'd0));

    // IPR gating and write/arbitration ordering.
    bus_wr(32'hFFFF_FE60, 4'b1000, 32'h0000_0000);
    {ici, ocia, ocib, ovi} = 4'hF;
    step_chk("ipr0_a", iv(0, 4'h5, 7'h48, 2'd0));
    step_chk("ipr0_b", iv(0, 4'h5, 7'h48, 2'd0));
    wr_chk("ipr3_wr_edge", 32'hFFFF_FE60, 4'b1000, 32'h0300_0000, iv(0, 4'h5, 7'h48, 2'd0));
    step_chk("ipr3_req", iv(1, 4'h3, 7'h48, 2'd0));
    wr_chk("ipr0_wr_edge", 32'hFFFF_FE60, 4'b1000, 32'h0000_0000, iv(1, 4'h3, 7'h48, 2'd0));
    step_chk("ipr0_withdraw", iv(0, 4'h3, 7'h48, 2'd0));

    // Upper IPR bits ignored, EN freeze, byte-lane gating.
    wr_chk("iprff_wr_edge", 32'hFFFF_FE60, 4'b1000, 32'hFF00_0000, iv(0, 4'h3, 7'h48, 2'd0));
    rd_chk("rd_e60_ff", 32'hFFFF_FE60, 32'h0F00_0000);
    en = 1'b0;
    step_chk("en0_hold", iv(0, 4'h3, 7'h48, 2'd0));
    wr_chk("en0_wr", 32'hFFFF_FE60, 4'b1000, 32'h0100_0000, iv(0, 4'h3, 7'h48, 2'd0));
    en = 1'b1;
    step_chk("en1_req", iv(1, 4'hF, 7'h48, 2'd0));
    wr_chk("ba_gate_wr", 32'hFFFF_FE60, 4'b0111, 32'h0100_0000, iv(1, 4'hF, 7'h48, 2'd0));
    rd_chk("rd_e60_gate", 32'hFFFF_FE60, 32'h0F00_0000);

    // CPU soft reset mid-request.
    res_n = 1'b0;
    step_chk("resn_int", iv(0, 4'h0, 7'h00, 2'd0));
    rd_chk("resn_e60", 32'hFFFF_FE60, 32'h0);
    rd_chk("resn_e64", 32'hFFFF_FE64, 32'h0);
    res_n = 1'b1;

    // Asynchronous reset mid-request.
    wr_chk("re_vcrc", 32'hFFFF_FE66, 4'b0011, 32'h0000_484A, iv(0, 4'h0, 7'h00, 2'd0));
    wr_chk("re_vcrd", 32'hFFFF_FE68, 4'b1100, 32'h5000_0000, iv(0, 4'h0, 7'h00, 2'd0));
    wr_chk("re_ipr", 32'hFFFF_FE60, 4'b1000, 32'h0700_0000, iv(0, 4'h0, 7'h00, 2'd0));
    step_chk("ipr7_req", iv(1, 4'h7, 7'h48, 2'd0));
    rd_chk("pre_rst_e64", 32'hFFFF_FE64, 32'h0000_484A);
    rst = 1'b1;
    #1;
    push_exp("rst_mid_int", 32'h0);
    pop_cmp(int_obs());
    push_exp("rst_mid_do", 32'h0);
    pop_cmp(bus_if.ibus_do);
    @(posedge clk);
    #1;
    rst = 1'b0;
    {ici, ocia, ocib, ovi} = 4'h0;
    rd_chk("post_rst_e60", 32'hFFFF_FE60, 32'h0);
    rd_chk("post_rst_e64", 32'hFFFF_FE64, 32'h0);
    rd_chk("post_rst_e68", 32'hFFFF_FE68, 32'h0);

`ifdef FRT_INTC_ACK_CNT_EN
    bus_wr(32'hFFFF_FE60, 4'b1000, 32'h0100_0000);
    ovi = 1'b1;
    for (int i = 0; i < 300; i++) begin
      w = 0;
      while (!bus_if.int_req && w < 8) begin
        tick();
        w++;
      end
      check_val("cnt_req", {31'h0, bus_if.int_req}, 32'd1);
      bus_if.int_ack = 1'b1;
      tick();
      bus_if.int_ack = 1'b0;
    end
    ovi = 1'b0;
    rd_chk("cnt_sat", 32'hFFFF_FE6C, 32'h0000_FF00);
    bus_wr(32'hFFFF_FE6C, 4'b1111, 32'h0);
`endif
    rd_chk("rd_e6c", 32'hFFFF_FE6C, 32'h0);

    if (sb_q.size() != 0) check_val("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sh7604_frt_intc.md
Name: sh7604_frt_intc

Overview:
- Interrupt-request stage directly downstream of the SH7604 free-running timer.
- Consumes the timer's four level IRQ lines (ICI, OCIA, OCIB, OVI) and arbitrates them by fixed internal priority.
- Applies the FRT priority level and the vector-number registers (IPRB FRT field, VCRC, VCRD), and presents one level/vector request to the CPU interrupt controller with a request/acknowledge handshake.
- Owns its registers on the on-chip IBUS.

Parameters:
- ACK_BLANK, 2, number of CE_R cycles that INT_REQ is held low after an acknowledge before re-arbitration (1..15).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- CE_R  in  1  rising-phase clock enable; registers and FSM update on it
- CE_F  in  1  falling-phase clock enable; read data is captured on it
- EN  in  1  block enable; when 0, FSM and registers hold
- RES_N  in  1  CPU soft reset, active-low, synchronous to CE_R
- ICI_IRQ, OCIA_IRQ, OCIB_IRQ, OVI_IRQ  in  1 each  level requests from the FRT
- IBUS_A  in  32  bus address
- IBUS_DI  in  32  write data, byte lanes: offset 0=[31:24], 1=[23:16], 2=[15:8], 3=[7:0]
- IBUS_DO  out  32  read data; 0 when not selected
- IBUS_BA  in  4  byte enables; BA[3]=lane [31:24]
- IBUS_WE, IBUS_REQ  in  1 each  write strobe, access request
- IBUS_BUSY  out  1  tied 0
- IBUS_ACT  out  1  high when the address is in this block's map
- INT_REQ  out  1  interrupt request to the CPU
- INT_LVL  out  4  request priority level
- INT_VEC  out  7  vector number
- INT_SRC  out  2  selected source: 0=ICI, 1=OCI, 2=OVI
- INT_ACK  in  1  CPU acknowledge, one CE_R-qualified cycle

Behaviour:
- Register map and reset values (RST or RES_N low → all 0):
  - FFFFFE60 byte: bits [3:0] = IPR (FRT level); bits [7:4] read 0, writes ignored.
  - FFFFFE66: VCRC.FICV[6:0] (bit 7 reads 0).
  - FFFFFE67: VCRC.FOCV[6:0].
  - FFFFFE68: VCRD.FOVV[6:0].
  - FFFFFE69: reads 0.
- Bus decode:
  - IBUS_ACT is high only for E60, E66, E67, E68, E69.
  - Writes occur when IBUS_REQ & IBUS_WE & ACT on CE_R; each enabled lane writes its byte.
  - Reads occur on CE_F and return the aligned longword image: E60 → {4'h0,IPR} on [31:24]; E64 word → VCRC on [15:0]; E68 word → VCRD on [31:16]; all other bits 0.
- Arbitration (combinational, evaluated each CE_R):
  - Priority order: ICI > OCI (OCIA|OCIB) > OVI.
  - Vector mapping: ICI → FICV, OCI → FOCV, OVI → FOVV.
- FSM states: IDLE, REQ, BLANK.
  - IDLE: if any source active and IPR≠0, go to REQ; register INT_LVL=IPR, INT_VEC, INT_SRC. INT_REQ goes high one CE_R after the IRQ rises.
  - REQ: INT_REQ=1. Each CE_R, re-arbitrate and update INT_VEC/INT_SRC/INT_LVL, so a higher-priority arrival replaces the vector.
  - REQ withdraw: all sources low, or IPR written to 0 → IDLE; INT_REQ drops next CE_R.
  - REQ on INT_ACK → BLANK. Vector/level/source are frozen from the ack cycle. If the ack coincides with a source change, the acked (pre-change) vector stands.
  - BLANK: INT_REQ=0; a counter runs ACK_BLANK CE_R cycles, then → IDLE. A still-asserted flag (not yet cleared by software) then re-requests.
  - INT_ACK outside REQ is ignored.
- Outputs at reset: INT_REQ=0, INT_LVL=0, INT_VEC=0, INT_SRC=0, IBUS_DO=0.
- EN=0 freezes state; RES_N low mid-request forces IDLE and INT_REQ=0 at the next CE_R.
- A register write and an arbitration update in the same CE_R: arbitration uses the pre-write values; the new values apply from the next CE_R.

Optional Feature:
- Macro: FRT_INTC_ACK_CNT_EN.
- Defined:
  - Three 8-bit saturating counters (ICI, OCI, OVI) increment on each accepted INT_ACK for the frozen INT_SRC; they saturate at FF.
  - Readable at FFFFFE6C ([31:24]=ICI, [23:16]=OCI, [15:8]=OVI).
  - Any write to E6C clears all three. IBUS_ACT also covers E6C–E6F.
  - Counters reset to 0.
- Undefined: no counters; E6C–E6F are outside the map, so IBUS_ACT=0 there.

Test Plan:
- IPR=5, FOCV=0x4A, pulse OCIA_IRQ high → INT_REQ=1 one CE_R later with INT_LVL=5, INT_VEC=0x4A, INT_SRC=1.
- While REQ is active for OVI (FOVV=0x50), raise ICI_IRQ (FICV=0x48) → INT_VEC becomes 0x48 and INT_SRC 0 on the next CE_R, with INT_REQ held high.
- INT_ACK in REQ with the flag still set → INT_REQ low for exactly ACK_BLANK (2) CE_R cycles, then high again with the same vector.
- IPR=0 with all IRQs high → INT_REQ stays 0; writing IPR=3 → request at level 3; writing IPR=0 while in REQ → withdraw next CE_R.
- Word write 0x4A4B to E66 with BA=0011 → read of E64 returns [15:0]=0x4A4B; byte write 0xFF to E60 → reads 0x0F on [31:24].
- Assert RST mid-REQ → INT_REQ, INT_VEC, INT_LVL and all registers are 0 immediately; with FRT_INTC_ACK_CNT_EN, 300 OVI acks → E6C reads [15:8]=0xFF.
